regfile_cmd_master: RTL and testbench



---
 rtl/regfile_cmd_pkg.sv | 19 +
 rtl/regfile_cmd_master.sv | 138 +++++++++++++
 tb/tb_regfile_cmd_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_cmd_pkg.sv
// Shared types and constants for the register-file command master.
// Frame layouts: write = CMD,ADDR,DATA; read = CMD,ADDR.
package regfile_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    localparam logic [7:0] WR_CMD_DEF     = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF     = 8'hBB;
    localparam int         WR_FRAME_BYTES = 3;
    localparam int         RD_FRAME_BYTES = 2;

endpackage

// File: rtl/regfile_cmd_master.sv
// Decodes UART command frames into register-file writes/reads and
// returns read bytes to the transmit path; all outputs registered.
module regfile_cmd_master
    import regfile_cmd_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               ADDR       = 4,
    parameter logic [WIDTH-1:0] WR_CMD     = WR_CMD_DEF,
    parameter logic [WIDTH-1:0] RD_CMD     = RD_CMD_DEF,
    parameter int               RD_TIMEOUT = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    input  logic             TX_Busy,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             Rd_Err
);

    localparam int           CW   = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(RD_TIMEOUT - 1);

    state_t           state, state_n;
    logic [ADDR-1:0]  addr_q, addr_n;
    logic [WIDTH-1:0] rd_byte, rd_byte_n;
    logic [CW-1:0]    cnt, cnt_n;

    logic             wr_en_n, rd_en_n, tx_vld_n, rd_err_n;
    logic [ADDR-1:0]  address_n;
    logic [WIDTH-1:0] wr_data_n, tx_data_n;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            addr_q    <= '0;
            rd_byte   <= '0;
            cnt       <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            Rd_Err    <= 1'b0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            rd_byte   <= rd_byte_n;
            cnt       <= cnt_n;
            WrEn      <= wr_en_n;
            RdEn      <= rd_en_n;
            Address   <= address_n;
            WrData    <= wr_data_n;
            TX_P_DATA <= tx_data_n;
            TX_D_VLD  <= tx_vld_n;
            Rd_Err    <= rd_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        rd_byte_n = rd_byte;
        cnt_n     = cnt;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        tx_vld_n  = 1'b0;
        rd_err_n  = 1'b0;
        address_n = Address;
        wr_data_n = WrData;
        tx_data_n = TX_P_DATA;

        unique case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_n = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_n = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_n  = RX_P_DATA[ADDR-1:0];
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                // Command values here are payload, never a resync.
                if (RX_D_VLD) begin
                    address_n = addr_q;
                    wr_data_n = RX_P_DATA;
                    wr_en_n   = 1'b1;
                    state_n   = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_n    = RX_P_DATA[ADDR-1:0];
                    address_n = RX_P_DATA[ADDR-1:0];
                    rd_en_n   = 1'b1;
                    cnt_n     = '0;
                    state_n   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RdData_VLD) begin
                    rd_byte_n = RdData;
                    state_n   = TX_SEND;
                end else if (cnt == LAST) begin
                    rd_err_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            TX_SEND: begin
                if (!TX_Busy) begin
                    tx_data_n = rd_byte;
                    tx_vld_n  = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed bench for regfile_cmd_master with a behavioural
// 16x8 register file answering RdEn one cycle later.
module tb_regfile_cmd_master;
    import regfile_cmd_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RdData;
    logic       RdData_VLD;
    logic       TX_Busy;
    logic       WrEn, RdEn, TX_D_VLD, Rd_Err;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    logic       rf_resp_en;
    logic [7:0] regs [16];
    int         total  = 0;
    int         passed = 0;
    int         ones;

    regfile_cmd_master dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RdData     (RdData),
        .RdData_VLD (RdData_VLD),
        .TX_Busy    (TX_Busy),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Address    (Address),
        .WrData     (WrData),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .Rd_Err     (Rd_Err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
            regs[2]    <= 8'h21;
            regs[3]    <= 8'h08;
            RdData_VLD <= 1'b0;
            RdData     <= 8'h00;
        end else begin
            if (WrEn) regs[Address] <= WrData;
            RdData_VLD <= RdEn & rf_resp_en;
            if (RdEn) RdData <= regs[Address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Call at a negedge; returns at the negedge after the strobe edge.
    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    initial begin
        RST        = 1'b0;
        RX_P_DATA  = 8'h00;
        RX_D_VLD   = 1'b0;
        TX_Busy    = 1'b0;
        rf_resp_en = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_wren", {31'b0, WrEn}, 0);
        chk("rst_rden", {31'b0, RdEn}, 0);
        chk("rst_txvld", {31'b0, TX_D_VLD}, 0);
        chk("rst_err", {31'b0, Rd_Err}, 0);
        chk("rst_outs", {Address, WrData, TX_P_DATA}, 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        RST = 1'b1;
        @(negedge CLK);

        // Stray bytes before any command byte
        send(8'h05);
        chk("stray_wr", {31'b0, WrEn}, 0);
        send(8'h3C);
        chk("stray_wr2", {31'b0, WrEn}, 0);
        chk("stray_rd", {31'b0, RdEn}, 0);
        chk("stray_state", 32'(dut.state), 32'(IDLE));

        // Read reset values of registers 2 and 3
        send(8'hBB);
        send(8'h02);
        chk("rd2_rden", {31'b0, RdEn}, 1);
        chk("rd2_addr", 32'(Address), 2);
        @(negedge CLK);
        chk("rd2_rden_off", {31'b0, RdEn}, 0);
        @(negedge CLK);
        chk("rd2_tx_early", {31'b0, TX_D_VLD}, 0);
        @(negedge CLK);
        chk("rd2_txvld", {31'b0, TX_D_VLD}, 1);
        chk("rd2_txdata", 32'(TX_P_DATA), 32'h21);
        @(negedge CLK);
        chk("rd2_txvld_off", {31'b0, TX_D_VLD}, 0);
        chk("rd2_txhold", 32'(TX_P_DATA), 32'h21);

        send(8'hBB);
        send(8'h03);
        repeat (3) @(negedge CLK);
        chk("rd3_txvld", {31'b0, TX_D_VLD}, 1);
        chk("rd3_txdata", 32'(TX_P_DATA), 32'h08);
        @(negedge CLK);

        // Write then back-to-back readback
        send(8'hAA);
        send(8'h05);
        chk("wr5_early", {31'b0, WrEn}, 0);
        send(8'h3C);
        chk("wr5_wren", {31'b0, WrEn}, 1);
        chk("wr5_addr", 32'(Address), 5);
        chk("wr5_data", 32'(WrData), 32'h3C);
        send(8'hBB);
        chk("wr5_wren_off", {31'b0, WrEn}, 0);
        chk("wr5_data_hold", 32'(WrData), 32'h3C);
        send(8'h05);
        chk("rd5_rden", {31'b0, RdEn}, 1);
        repeat (3) @(negedge CLK);
        chk("rd5_txvld", {31'b0, TX_D_VLD}, 1);
        chk("rd5_txdata", 32'(TX_P_DATA), 32'h3C);
        @(negedge CLK);

        // Read held off by TX_Busy for 10 cycles
        TX_Busy = 1'b1;
        send(8'hBB);
        send(8'h02);
        ones = 0;
        repeat (10) begin
            @(negedge CLK);
            if (TX_D_VLD) ones++;
        end
        chk("busy_held", 32'(ones), 0);
        TX_Busy = 1'b0;
        @(negedge CLK);
        chk("busy_txvld", {31'b0, TX_D_VLD}, 1);
        chk("busy_txdata", 32'(TX_P_DATA), 32'h21);
        ones = 0;
        repeat (4) begin
            @(negedge CLK);
            if (TX_D_VLD) ones++;
        end
        chk("busy_once", 32'(ones), 0);

        // Read timeout
        rf_resp_en = 1'b0;
        send(8'hBB);
        send(8'h07);
        ones = 0;
        repeat (7) begin
            @(negedge CLK);
            if (Rd_Err) ones++;
        end
        chk("to_early", 32'(ones), 0);
        @(negedge CLK);
        chk("to_err", {31'b0, Rd_Err}, 1);
        chk("to_txvld", {31'b0, TX_D_VLD}, 0);
        @(negedge CLK);
        chk("to_err_off", {31'b0, Rd_Err}, 0);
        chk("to_state", 32'(dut.state), 32'(IDLE));
        rf_resp_en = 1'b1;
        send(8'hAA);
        send(8'h09);
        send(8'h5A);
        chk("to_wr_wren", {31'b0, WrEn}, 1);
        chk("to_wr_vals", {24'b0, Address, 4'b0} | 32'(WrData) << 16,
            {8'h00, 8'h5A, 8'h00, 8'h90});
        @(negedge CLK);

        // Unknown byte dropped, address truncated, AA as payload
        send(8'h55);
        chk("unk_state", 32'(dut.state), 32'(IDLE));
        send(8'hAA);
        send(8'h1F);
        send(8'hFF);
        chk("trunc_wren", {31'b0, WrEn}, 1);
        chk("trunc_addr", 32'(Address), 32'hF);
        chk("trunc_data", 32'(WrData), 32'hFF);
        send(8'hAA);
        send(8'h04);
        send(8'hAA);
        chk("payload_wren", {31'b0, WrEn}, 1);
        chk("payload_data", 32'(WrData), 32'hAA);
        @(negedge CLK);

        // Reset in the middle of a write frame
        send(8'hAA);
        send(8'h01);
        RST = 1'b0;
        #1;
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        chk("mid_rst_outs", {Address, WrData, TX_P_DATA}, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(8'h77);
        chk("mid_rst_nowr", {31'b0, WrEn}, 0);
        chk("mid_rst_idle", 32'(dut.state), 32'(IDLE));
        send(8'hAA);
        send(8'h02);
        send(8'h11);
        chk("post_rst_wr", {27'b0, WrEn, Address}, {27'b0, 1'b1, 4'h2});
        @(negedge CLK);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
